// File: rtl/button_bounce_gen.sv
// button_bounce_gen
//   Emulates a mechanical push-button: on request, bouncy_out makes
//   2*BOUNCES+1 toggles separated by pseudo-random gaps of 1..2^GAP_W
//   cycles, holds for SETTLE_CYCLES and then pulses done. Intended as a
//   stimulus source for debounce logic.
//
// Parameters
//   BOUNCES       extra bounce pairs per transition (0 allowed)
//   GAP_W         width of the random gap field; gap = lfsr[GAP_W-1:0] + 1
//   SETTLE_CYCLES stable hold after the final toggle before done (>= 1)
//   SEED          nonzero LFSR reset value
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   start         request a transition of bouncy_out to target_level
//   target_level  desired settled level, sampled with start
//   bouncy_out    registered bouncing output
//   busy          high while a transition is in progress
//   done          one-cycle pulse when bouncy_out has settled
module button_bounce_gen #(
    parameter int          BOUNCES       = 5,
    parameter int          GAP_W         = 3,
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic target_level,
    output logic bouncy_out,
    output logic busy,
    output logic done
);

    localparam int TOG_MAX = 2 * BOUNCES + 1;
    localparam int TOG_W   = $clog2(TOG_MAX + 1);
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SETTLE
    } state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic [GAP_W:0]     gap;
    logic [GAP_W:0]     gap_cnt;
    logic [TOG_W-1:0]   toggle_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic               target_q;

    // Galois LFSR, mask 16'hB400, shifting right.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_comb begin
        gap = {1'b0, lfsr[GAP_W-1:0]} + {{GAP_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lfsr       <= SEED;
            gap_cnt    <= '0;
            toggle_cnt <= '0;
            settle_cnt <= '0;
            target_q   <= 1'b0;
            bouncy_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (target_level != bouncy_out) begin
                            target_q   <= target_level;
                            toggle_cnt <= TOG_W'(TOG_MAX);
                            gap_cnt    <= gap;
                            busy       <= 1'b1;
                            state      <= WAIT;
                        end else begin
                            // Already at the requested level: acknowledge only.
                            done <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (gap_cnt > (GAP_W + 1)'(1)) begin
                        gap_cnt <= gap_cnt - (GAP_W + 1)'(1);
                    end else begin
                        toggle_cnt <= toggle_cnt - TOG_W'(1);
                        if (toggle_cnt == TOG_W'(1)) begin
                            // The odd toggle count always lands on the target;
                            // driving target_q here is the same value as ~bouncy_out.
                            bouncy_out <= target_q;
                            settle_cnt <= SET_W'(SETTLE_CYCLES);
                            state      <= SETTLE;
                        end else begin
                            bouncy_out <= ~bouncy_out;
                            gap_cnt    <= gap;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt > SET_W'(1)) begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end else begin
                        settle_cnt <= '0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Directed bench for button_bounce_gen. Two instances share clock and reset:
// u_dut (BOUNCES=5) and u_dut0 (BOUNCES=0). Expected toggle edges are derived
// from an LFSR reference counted in clock edges since reset release.
module tb_button_bounce_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start;
    logic [1:0] tgt;
    logic [1:0] bo;
    logic [1:0] bz;
    logic [1:0] dn;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    button_bounce_gen #(
        .BOUNCES(5), .GAP_W(3), .SETTLE_CYCLES(16), .SEED(SEED)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start[0]), .target_level(tgt[0]),
        .bouncy_out(bo[0]), .busy(bz[0]), .done(dn[0])
    );

    button_bounce_gen #(
        .BOUNCES(0), .GAP_W(3), .SETTLE_CYCLES(16), .SEED(SEED)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start[1]), .target_level(tgt[1]),
        .bouncy_out(bo[1]), .busy(bz[1]), .done(dn[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reference LFSR value just before clock edge n (edge 0 = first after release).
    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] v;
        v = SEED;
        for (int i = 0; i < n; i++)
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        return v;
    endfunction

    function automatic int gap_at(input int n);
        logic [15:0] v;
        v = lfsr_at(n);
        return int'(v[2:0]) + 1;
    endfunction

    // Request a transition on instance sel and follow it to done.
    // inject pulses start with the opposite target while busy.
    task automatic run_tr(input int sel, input logic tgt_v, input int ntog, input bit inject);
        int   acc, e, ndone, done_e, busy_low, exp_e, g;
        logic prev;
        int   tog[$];
        @(negedge clk);
        start[sel] = 1'b1;
        tgt[sel]   = tgt_v;
        acc        = edge_cnt;
        prev       = bo[sel];
        @(posedge clk); #1;
        start[sel] = 1'b0;
        ndone = 0; done_e = -1; busy_low = 0;
        for (int c = 0; c < 300; c++) begin
            e = edge_cnt - 1;
            if (bo[sel] !== prev) begin
                tog.push_back(e);
                prev = bo[sel];
            end
            if (dn[sel] === 1'b1) begin
                ndone  = 1;
                done_e = e;
                break;
            end
            if (bz[sel] !== 1'b1) busy_low++;
            if (inject && c == 3) begin
                start[sel] = 1'b1;
                tgt[sel]   = ~tgt_v;
            end else begin
                start[sel] = 1'b0;
            end
            @(posedge clk); #1;
        end
        start[sel] = 1'b0;
        check("busy_held", busy_low, 0);
        check("done_seen", ndone, 1);
        check("toggle_count", tog.size(), ntog);
        check("final_level", int'(bo[sel]), int'(tgt_v));
        check("busy_after_done", int'(bz[sel]), 0);
        exp_e = acc + gap_at(acc);
        for (int i = 0; i < tog.size(); i++) begin
            check("toggle_edge", tog[i], exp_e);
            if (i > 0) begin
                g = tog[i] - tog[i-1];
                check("gap_range", int'(g >= 1 && g <= 8), 1);
            end
            exp_e = exp_e + gap_at(exp_e);
        end
        if (tog.size() > 0)
            check("settle_len", done_e - tog[tog.size()-1], 16);
    endtask

    initial begin
        int ntg;
        logic prev;
        reset = 1'b1;
        start = '0;
        tgt   = '0;
        #12;
        check("rst_bouncy", int'(bo), 0);
        check("rst_busy", int'(bz), 0);
        check("rst_done", int'(dn), 0);
        @(negedge clk);
        reset = 1'b0;

        // 0 -> 1 with five bounce pairs, right after reset.
        run_tr(0, 1'b1, 11, 1'b0);

        // Same-level request: done next cycle, no toggle, never busy.
        @(negedge clk);
        start[0] = 1'b1;
        tgt[0]   = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        check("same_done", int'(dn[0]), 1);
        check("same_level", int'(bo[0]), 1);
        check("same_busy", int'(bz[0]), 0);
        @(posedge clk); #1;
        check("same_done_pulse", int'(dn[0]), 0);
        check("same_busy2", int'(bz[0]), 0);

        // 1 -> 0 with a conflicting start while busy, then back-to-back 0 -> 1.
        run_tr(0, 1'b0, 11, 1'b1);
        run_tr(0, 1'b1, 11, 1'b1);

        // Asynchronous reset mid-WAIT, after the second toggle (bouncy_out=1).
        @(negedge clk);
        start[0] = 1'b1;
        tgt[0]   = 1'b0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        ntg  = 0;
        prev = bo[0];
        for (int c = 0; c < 60 && ntg < 2; c++) begin
            @(posedge clk); #1;
            if (bo[0] !== prev) begin
                ntg++;
                prev = bo[0];
            end
        end
        check("mid_wait_reached", ntg, 2);
        check("mid_wait_level", int'(bo[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_bouncy", int'(bo[0]), 0);
        check("async_busy", int'(bz[0]), 0);
        check("async_done", int'(dn[0]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Fresh run from SEED: same gap sequence as the first run.
        run_tr(0, 1'b1, 11, 1'b0);

        // BOUNCES=0 instance: single toggle, then settle.
        run_tr(1, 1'b1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
